maxunpool: RTL and testbench

//  Inverse of the maxpool stage. Takes a pooled map plus the per-window argmax indices
//  and scatters each pooled value back to its argmax position in a full-size map.
//  All other positions are zero. Feeds the backward/reconstruction path after maxpool.

---
 rtl/maxunpool.sv | 147 ++++++++++++++
 tb/tb_maxunpool.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxunpool.sv
// Max-unpooling stage: scatters each pooled value back to its argmax position
// in a full-size map, one pooled element per clock, zeros everywhere else.
module maxunpool #(
   parameter int UNPOOLED_SIZE = 26,
   parameter int POOLED_SIZE   = 2,
   parameter int ELEMENT_SIZE  = 20
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic                                                   en,
   input  logic [POOLED_SIZE*POOLED_SIZE*ELEMENT_SIZE-1:0]        i_featuremap,
   input  logic [POOLED_SIZE*POOLED_SIZE*$clog2((UNPOOLED_SIZE/POOLED_SIZE)*(UNPOOLED_SIZE/POOLED_SIZE))-1:0] i_argmax,
   output logic [UNPOOLED_SIZE*UNPOOLED_SIZE*ELEMENT_SIZE-1:0]    o_featuremap,
   output logic                                                   done,
   output logic                                                   err
);

   localparam int POOL  = UNPOOLED_SIZE / POOLED_SIZE;
   localparam int IDX_W = $clog2(POOL * POOL);
   localparam int NP    = POOLED_SIZE * POOLED_SIZE;
   localparam int NU    = UNPOOLED_SIZE * UNPOOLED_SIZE;
   localparam int P_W   = (NP > 1) ? $clog2(NP) : 1;

   localparam logic [P_W-1:0]   P_LAST  = P_W'(NP - 1);
   localparam logic [IDX_W:0]   K_LIMIT = (IDX_W + 1)'(POOL * POOL);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCATTER,
      S_DONE
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic [NP*ELEMENT_SIZE-1:0] fm_reg;
   logic [NP*IDX_W-1:0]        am_reg;
   logic [P_W-1:0]             p_reg;

   logic                       start;
   logic                       scatter;
   logic                       last;
   logic                       release_done;

   logic [IDX_W-1:0]           k_cur;
   logic [ELEMENT_SIZE-1:0]    val_cur;
   logic                       k_bad;
   logic [NU-1:0]              hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      start        = 1'b0;
      scatter      = 1'b0;
      last         = 1'b0;
      release_done = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (en) begin
               start      = 1'b1;
               state_next = S_SCATTER;
            end
         end
         S_SCATTER: begin
            scatter = 1'b1;
            if (p_reg == P_LAST) begin
               last       = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            // A fresh start requires en to drop first, so a held en cannot retrigger.
            if (!en) begin
               release_done = 1'b1;
               state_next   = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign k_cur   = am_reg[p_reg*IDX_W +: IDX_W];
   assign val_cur = fm_reg[p_reg*ELEMENT_SIZE +: ELEMENT_SIZE];
   assign k_bad   = {1'b0, k_cur} >= K_LIMIT;

   // Each output element owns one (window, local index) pair; it is written only
   // when that window is being scattered and its argmax selects this position.
   genvar gi;
   generate
      for (gi = 0; gi < NU; gi++) begin : g_elem
         localparam int R = gi / UNPOOLED_SIZE;
         localparam int C = gi % UNPOOLED_SIZE;
         if ((R < POOLED_SIZE * POOL) && (C < POOLED_SIZE * POOL)) begin : g_cov
            localparam logic [P_W-1:0]   WIN = P_W'((R / POOL) * POOLED_SIZE + (C / POOL));
            localparam logic [IDX_W-1:0] LI  = IDX_W'((R % POOL) * POOL + (C % POOL));
            assign hit[gi] = scatter && (p_reg == WIN) && (k_cur == LI);
         end else begin : g_uncov
            assign hit[gi] = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fm_reg       <= '0;
         am_reg       <= '0;
         p_reg        <= '0;
         err          <= 1'b0;
         done         <= 1'b0;
         o_featuremap <= '0;
      end else begin
         if (start) begin
            fm_reg <= i_featuremap;
            am_reg <= i_argmax;
            p_reg  <= '0;
            err    <= 1'b0;
         end
         if (scatter) begin
            p_reg <= p_reg + 1'b1;
            if (k_bad) begin
               err <= 1'b1;
            end
         end
         if (last) begin
            done <= 1'b1;
         end
         if (release_done) begin
            done <= 1'b0;
         end
         for (int e = 0; e < NU; e++) begin
            if (start) begin
               o_featuremap[e*ELEMENT_SIZE +: ELEMENT_SIZE] <= '0;
            end else if (hit[e]) begin
               o_featuremap[e*ELEMENT_SIZE +: ELEMENT_SIZE] <= val_cur;
            end
         end
      end
   end

endmodule

// File: tb/tb_maxunpool.sv
// Randomized self-checking bench for maxunpool against a scatter model built
// directly from the window/argmax arithmetic.
module tb_maxunpool;

   localparam int U     = 26;
   localparam int PS    = 2;
   localparam int E     = 20;
   localparam int POOL  = U / PS;
   localparam int IW    = 8;
   localparam int NP    = PS * PS;
   localparam int OUT_W = U * U * E;

   logic                clk;
   logic                rst;
   logic                en;
   logic [NP*E-1:0]     i_featuremap;
   logic [NP*IW-1:0]    i_argmax;
   logic [OUT_W-1:0]    o_featuremap;
   logic                done;
   logic                err;

   int tests_run    = 0;
   int tests_failed = 0;

   maxunpool #(
      .UNPOOLED_SIZE (U),
      .POOLED_SIZE   (PS),
      .ELEMENT_SIZE  (E)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .i_featuremap (i_featuremap),
      .i_argmax     (i_argmax),
      .o_featuremap (o_featuremap),
      .done         (done),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: place each pooled value at its window origin plus (k/POOL, k%POOL).
   function automatic logic [OUT_W-1:0] model_map(input logic [E-1:0] v [NP], input logic [IW-1:0] k [NP]);
      logic [OUT_W-1:0] m;
      m = '0;
      for (int w = 0; w < NP; w++) begin
         int pr, pc, r, c;
         pr = w / PS;
         pc = w % PS;
         if (int'(k[w]) < POOL * POOL) begin
            r = pr * POOL + int'(k[w]) / POOL;
            c = pc * POOL + int'(k[w]) % POOL;
            m[(r*U+c)*E +: E] = v[w];
         end
      end
      return m;
   endfunction

   function automatic logic model_err(input logic [IW-1:0] k [NP]);
      logic bad;
      bad = 1'b0;
      for (int w = 0; w < NP; w++) begin
         if (int'(k[w]) >= POOL * POOL) bad = 1'b1;
      end
      return bad;
   endfunction

   function automatic int first_diff(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b);
      for (int e = 0; e < U * U; e++) begin
         if (a[e*E +: E] !== b[e*E +: E]) return e;
      end
      return -1;
   endfunction

   task automatic drive_inputs(input logic [E-1:0] v [NP], input logic [IW-1:0] k [NP]);
      for (int w = 0; w < NP; w++) begin
         i_featuremap[w*E +: E]  = v[w];
         i_argmax[w*IW +: IW]    = k[w];
      end
   endtask

   // Starts one op and returns the number of edges after the start edge until done,
   // or -1 if done never rose within the budget. Optionally scrambles inputs/en meanwhile.
   task automatic do_op(input logic [E-1:0] v [NP], input logic [IW-1:0] k [NP],
                        input bit toggle, output int lat);
      lat = -1;
      @(negedge clk);
      drive_inputs(v, k);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (toggle) begin
            i_featuremap = {$urandom, $urandom, $urandom};
            i_argmax     = 32'($urandom);
            en           = 1'($urandom);
         end
         @(negedge clk);
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      en = 1'b0;
   endtask

   task automatic check_op(input string name, input logic [E-1:0] v [NP], input logic [IW-1:0] k [NP], input int lat);
      logic [OUT_W-1:0] exp_map;
      logic             exp_err;
      int               d;
      exp_map = model_map(v, k);
      exp_err = model_err(k);
      tests_run++;
      if (lat !== NP) begin
         tests_failed++;
         $display("FAIL %s_latency: got %0d edges, expected %0d", name, lat, NP);
      end
      tests_run++;
      if (o_featuremap !== exp_map) begin
         tests_failed++;
         d = first_diff(o_featuremap, exp_map);
         $display("FAIL %s_map: element %0d (r=%0d c=%0d) got %h expected %h", name, d, d / U, d % U,
                  o_featuremap[d*E +: E], exp_map[d*E +: E]);
      end
      tests_run++;
      if (err !== exp_err) begin
         tests_failed++;
         $display("FAIL %s_err: got %b expected %b", name, err, exp_err);
      end
      $display("[TB] %s: idx=%0d,%0d,%0d,%0d lat=%0d err=%b", name, k[0], k[1], k[2], k[3], lat, err);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      en  = 1'b0;
      i_featuremap = {$urandom, $urandom, $urandom};
      i_argmax     = 32'($urandom);
      repeat (3) @(negedge clk);
      tests_run++;
      if (o_featuremap !== '0) begin
         tests_failed++;
         $display("FAIL reset_map: nonzero element %0d", first_diff(o_featuremap, '0));
      end
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_err: got %b expected 0", err);
      end
      rst = 1'b1;
      repeat (5) @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || o_featuremap !== '0) begin
         tests_failed++;
         $display("FAIL idle_hold: done=%b map_nonzero=%b expected done=0 map zero", done, o_featuremap !== '0);
      end
      $display("[TB] test_reset: done=%b err=%b", done, err);
   endtask

   task automatic test_basic();
      logic [E-1:0]  v [NP];
      logic [IW-1:0] k [NP];
      int lat;
      for (int w = 0; w < NP; w++) begin
         v[w] = E'(w + 1);
         k[w] = '0;
      end
      do_op(v, k, 1'b0, lat);
      check_op("basic_idx0", v, k, lat);
      tests_run++;
      if (o_featuremap[(13*U+13)*E +: E] !== 20'd4) begin
         tests_failed++;
         $display("FAIL basic_13_13: got %0d expected 4", o_featuremap[(13*U+13)*E +: E]);
      end
   endtask

   task automatic test_corner();
      logic [E-1:0]  v [NP];
      logic [IW-1:0] k [NP];
      int lat;
      for (int w = 0; w < NP; w++) begin
         v[w] = E'(w + 5);
         k[w] = 8'd168;
      end
      do_op(v, k, 1'b0, lat);
      check_op("corner_idx168", v, k, lat);
      tests_run++;
      if (o_featuremap[(25*U+25)*E +: E] !== 20'd8) begin
         tests_failed++;
         $display("FAIL corner_25_25: got %0d expected 8", o_featuremap[(25*U+25)*E +: E]);
      end
   endtask

   task automatic test_out_of_range();
      logic [E-1:0]  v [NP];
      logic [IW-1:0] k [NP];
      int lat;
      for (int w = 0; w < NP; w++) begin
         v[w] = E'($urandom_range(1, 20'hFFFFF));
         k[w] = IW'($urandom_range(0, 168));
      end
      k[1] = 8'd200;
      do_op(v, k, 1'b0, lat);
      check_op("out_of_range", v, k, lat);
   endtask

   task automatic test_second_op_and_toggle();
      logic [E-1:0]  v [NP];
      logic [IW-1:0] k [NP];
      int lat;
      for (int w = 0; w < NP; w++) begin
         v[w] = E'($urandom_range(1, 20'hFFFFF));
         k[w] = IW'($urandom_range(169, 255));
      end
      do_op(v, k, 1'b0, lat);
      check_op("first_op_bad", v, k, lat);
      for (int w = 0; w < NP; w++) begin
         v[w] = E'($urandom_range(1, 20'hFFFFF));
         k[w] = IW'($urandom_range(0, 168));
      end
      do_op(v, k, 1'b1, lat);
      check_op("second_op_toggle", v, k, lat);
   endtask

   task automatic test_reset_mid();
      logic [E-1:0]  v [NP];
      logic [IW-1:0] k [NP];
      int lat;
      for (int w = 0; w < NP; w++) begin
         v[w] = E'($urandom_range(1, 20'hFFFFF));
         k[w] = IW'($urandom_range(0, 168));
      end
      @(negedge clk);
      drive_inputs(v, k);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (o_featuremap !== '0 || done !== 1'b0 || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: map_nonzero=%b done=%b err=%b expected all clear",
                  o_featuremap !== '0, done, err);
      end
      $display("[TB] test_reset_mid: async clear done=%b", done);
      @(negedge clk);
      rst = 1'b1;
      for (int w = 0; w < NP; w++) begin
         v[w] = E'($urandom_range(0, 20'hFFFFF));
         k[w] = IW'($urandom_range(0, 168));
      end
      do_op(v, k, 1'b0, lat);
      check_op("after_reset_mid", v, k, lat);
   endtask

   task automatic test_random();
      logic [E-1:0]  v [NP];
      logic [IW-1:0] k [NP];
      int lat;
      for (int t = 0; t < 10; t++) begin
         for (int w = 0; w < NP; w++) begin
            v[w] = E'($urandom);
            if ($urandom_range(0, 7) == 0) k[w] = IW'($urandom_range(169, 255));
            else                           k[w] = IW'($urandom_range(0, 168));
         end
         do_op(v, k, t[0], lat);
         check_op("random", v, k, lat);
      end
   endtask

   initial begin
      rst          = 1'b0;
      en           = 1'b0;
      i_featuremap = '0;
      i_argmax     = '0;
      test_reset();
      test_basic();
      test_corner();
      test_out_of_range();
      test_second_op_and_toggle();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
